// File: rtl/balanca_pkg.sv
// Shared constants and types for the Balanca price path.
// Used by the cents-to-euros converter and the display helpers.
package balanca_pkg;

  localparam int unsigned CENT_DIVISOR = 100;
  localparam int FRAC_W = 7;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational split of a 0..99 value into two BCD digits.
// Shared by the price and weight display paths.
module bin2bcd_2d
  import balanca_pkg::*;
(
  input  logic [FRAC_W-1:0] bin,
  output logic [BCD_W-1:0]  tens,
  output logic [BCD_W-1:0]  ones
);

  assign tens = BCD_W'(bin / 7'd10);
  assign ones = BCD_W'(bin % 7'd10);

endmodule

// File: rtl/centimos_euros_seq.sv
// Iterative cents-to-euros converter: restoring division by 100,
// one quotient bit per cycle, with a BCD split of the remainder.
module centimos_euros_seq
  import balanca_pkg::*;
#(
  parameter int CENT_W = 14,
  parameter int EURO_W = CENT_W - 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CENT_W-1:0] in_cents,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EURO_W-1:0] out_euros,
  output logic [FRAC_W-1:0] out_frac,
  output logic [BCD_W-1:0]  out_tens,
  output logic [BCD_W-1:0]  out_ones
);

  localparam int CNT_W = $clog2(CENT_W);

  conv_state_t state;
  logic [CENT_W-1:0] dvd;
  logic [CENT_W-1:0] dvd_nxt;
  logic [FRAC_W-1:0] rem;
  logic [FRAC_W-1:0] rem_nxt;
  logic [7:0]        rem_sh;
  logic [CNT_W-1:0]  cnt;
  logic              qbit;
  logic [BCD_W-1:0]  tens;
  logic [BCD_W-1:0]  ones;

  // Quotient bits shift into the vacated low end of the dividend.
  always_comb begin
    rem_sh  = {rem, dvd[CENT_W-1]};
    qbit    = rem_sh >= 8'(CENT_DIVISOR);
    rem_nxt = qbit ? FRAC_W'(rem_sh - 8'(CENT_DIVISOR))
                   : FRAC_W'(rem_sh);
    dvd_nxt = {dvd[CENT_W-2:0], qbit};
  end

  bin2bcd_2d u_bcd (
    .bin  (rem_nxt),
    .tens (tens),
    .ones (ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      rem       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_euros <= '0;
      out_frac  <= '0;
      out_tens  <= '0;
      out_ones  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvd      <= in_cents;
            rem      <= '0;
            cnt      <= CNT_W'(CENT_W - 1);
            in_ready <= 1'b0;
            state    <= DIV;
          end else begin
            in_ready <= 1'b1;
          end
        end
        DIV: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_euros <= dvd_nxt[EURO_W-1:0];
            out_frac  <= rem_nxt;
            out_tens  <= tens;
            out_ones  <= ones;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
